// File: rtl/prog_sequencer_if.sv
// Handshake bundle between the bench/controller side and the program
// sequencer: start/halt requests in, PC load and run control out.
interface prog_sequencer_if #(
  parameter int PC_WIDTH = 11
);
  logic                start;
  logic                halt;
  logic                fetch_load;
  logic [PC_WIDTH-1:0] load_addr;
  logic                run_en;
  logic [1:0]          prog_num;
  logic                done;
  logic                timeout;

  // Requester side: issues start, reports halt, observes sequencer status.
  modport master (
    output start, halt,
    input  fetch_load, load_addr, run_en, prog_num, done, timeout
  );

  // Sequencer side.
  modport slave (
    input  start, halt,
    output fetch_load, load_addr, run_en, prog_num, done, timeout
  );
endinterface

// File: rtl/prog_sequencer.sv
// Program-level sequencer: on start, loads the base address of the next
// program (0,1,2 round-robin) into the PC, enables execution until halt,
// then reports done. Optional RUN watchdog is built when the macro
// PROG_SEQ_WATCHDOG_EN is defined; otherwise timeout is tied low and RUN
// exits only on halt or reset.
module prog_sequencer #(
  parameter int                  PC_WIDTH   = 11,
  parameter logic [PC_WIDTH-1:0] PROG0_BASE = 11'd0,
  parameter logic [PC_WIDTH-1:0] PROG1_BASE = 11'd256,
  parameter logic [PC_WIDTH-1:0] PROG2_BASE = 11'd512
`ifdef PROG_SEQ_WATCHDOG_EN
  ,
  parameter int                  WDOG_CYCLES = 4096
`endif
) (
  input logic            clk,
  input logic            reset,
  prog_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state_reg, state_next;
  logic [1:0] prog_num_reg, prog_num_next;

`ifdef PROG_SEQ_WATCHDOG_EN
  localparam int CNT_W = $clog2(WDOG_CYCLES + 1);

  logic             timeout_reg, timeout_next;
  logic [CNT_W-1:0] wdog_cnt_reg, wdog_cnt_next;

  // State, program index, timeout flag and RUN-cycle counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      prog_num_reg <= 2'd0;
      timeout_reg  <= 1'b0;
      wdog_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      prog_num_reg <= prog_num_next;
      timeout_reg  <= timeout_next;
      wdog_cnt_reg <= wdog_cnt_next;
    end
  end

  // Next-state logic; the watchdog fires on the WDOG_CYCLES-th RUN cycle
  // unless halt arrives in that same cycle.
  always_comb begin
    state_next    = state_reg;
    prog_num_next = prog_num_reg;
    timeout_next  = timeout_reg;
    wdog_cnt_next = wdog_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next    = LOAD;
          timeout_next  = 1'b0;
          wdog_cnt_next = '0;
        end
      end
      LOAD: begin
        state_next = RUN;
      end
      RUN: begin
        wdog_cnt_next = wdog_cnt_reg + 1'b1;
        if (bus.halt) begin
          state_next   = DONE;
          timeout_next = 1'b0;
        end else if (wdog_cnt_reg == CNT_W'(WDOG_CYCLES - 1)) begin
          state_next   = DONE;
          timeout_next = 1'b1;
        end
      end
      DONE: begin
        if (bus.start) begin
          state_next    = LOAD;
          prog_num_next = (prog_num_reg == 2'd2) ? 2'd0 : prog_num_reg + 2'd1;
          timeout_next  = 1'b0;
          wdog_cnt_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.timeout = timeout_reg;
`else
  // State and program index registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      prog_num_reg <= 2'd0;
    end else begin
      state_reg    <= state_next;
      prog_num_reg <= prog_num_next;
    end
  end

  // Next-state logic; RUN leaves only on halt.
  always_comb begin
    state_next    = state_reg;
    prog_num_next = prog_num_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) state_next = LOAD;
      end
      LOAD: begin
        state_next = RUN;
      end
      RUN: begin
        if (bus.halt) state_next = DONE;
      end
      DONE: begin
        if (bus.start) begin
          state_next    = LOAD;
          prog_num_next = (prog_num_reg == 2'd2) ? 2'd0 : prog_num_reg + 2'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.timeout = 1'b0;
`endif

  // Control outputs decode directly from the registered state.
  assign bus.fetch_load = (state_reg == LOAD);
  assign bus.run_en     = (state_reg == RUN);
  assign bus.done       = (state_reg == DONE);
  assign bus.prog_num   = prog_num_reg;

  // Base address of the current program; follows prog_num in every state.
  always_comb begin
    case (prog_num_reg)
      2'd1:    bus.load_addr = PROG1_BASE;
      2'd2:    bus.load_addr = PROG2_BASE;
      default: bus.load_addr = PROG0_BASE;
    endcase
  end

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Program-level controller for the instruction fetch unit. It accepts the test bench's `start` request and selects the next program in the series. It loads that program's base address into the PC, enables execution until the core reports `halt`, then signals `done` back to the bench. It sits between the test bench and the fetch/PC register, owning the PC load and the global run enable.

## Interface
- `PC_WIDTH`, 11, width of PC and base addresses
- `PROG0_BASE`, 0, start address of program 0
- `PROG1_BASE`, 256, start address of program 1
- `PROG2_BASE`, 512, start address of program 2
- `WDOG_CYCLES`, 4096, RUN-cycle limit before forced stop (watchdog builds only)

Ports:
- `clk`  in  1  clock, all state changes on posedge
- `reset`  in  1  reset, synchronous, active-high
- `start`  in  1  bench request to run next program; level sampled each cycle
- `halt`  in  1  core executed halt instruction; valid only in RUN
- `fetch_load`  out  1  one-cycle pulse: PC <= `load_addr`
- `load_addr`  out  PC_WIDTH  base address of current program
- `run_en`  out  1  fetch/pipeline advance enable
- `prog_num`  out  2  current program index, 0..2
- `done`  out  1  program finished; held until next accepted start
- `timeout`  out  1  last program ended by watchdog, not halt

## Operation
- FSM states: IDLE, LOAD, RUN, DONE. All outputs registered or decoded from registered state only.
- Reset values: state=IDLE, `prog_num`=0, `fetch_load`=0, `run_en`=0, `done`=0, `timeout`=0, `load_addr`=`PROG0_BASE`.
- IDLE: `start`=1 -> LOAD with `prog_num` unchanged (first program is 0).
- LOAD: `fetch_load`=1 for exactly one cycle, `load_addr`=base[`prog_num`] -> RUN unconditionally.
- RUN: `run_en`=1. `halt`=1 -> DONE with `timeout`=0.
- DONE: `done`=1, `run_en`=0. `start`=1 -> `prog_num` <= (`prog_num`==2 ? 0 : `prog_num`+1) -> LOAD; `done` and `timeout` clear entering LOAD.
- `load_addr` is combinational mux of `prog_num` over the three base parameters. It is stable in all states.
- `start` is ignored in LOAD and RUN. A held `start` in DONE is accepted once, then ignored until DONE is re-entered.
- `halt` is ignored outside RUN.
- In RUN, `start` and `halt` both high: halt taken; start ignored this cycle.
- `reset` overrides everything in any state, including mid-RUN; the next cycle shows reset values.

## Timing
- `start` high at edge n (IDLE/DONE) -> `fetch_load`=1 during cycle n+1 -> `run_en`=1 from cycle n+2.
- `done` falls in cycle n+1.
- `halt` high at edge m (RUN) -> `run_en`=0 and `done`=1 from cycle m+1.
- The first fetched instruction of a program is at `load_addr`, one cycle after the `fetch_load` pulse.
- Minimum program turnaround, start to done, is 3 cycles (halt in the first RUN cycle).

## Configuration
- `PROG_SEQ_WATCHDOG_EN` defined:
  - A RUN-cycle counter of ceil(log2(`WDOG_CYCLES`+1)) bits clears on entry to LOAD and increments each RUN cycle.
  - When the count reaches `WDOG_CYCLES` without `halt`, the FSM goes to DONE with `timeout`=1.
  - `halt` in that same cycle wins: `timeout`=0.
- Undefined: no counter; `timeout` tied 0; RUN exits only on `halt` or `reset`.

## Test plan
- Reset then idle: `reset` 2 cycles, `start`=0 for 10 cycles -> all outputs 0, `prog_num`=0, `load_addr`=0.
- Single program: `start` pulse at cycle 5, `halt` at cycle 20 -> `fetch_load` high in cycle 6 only; `load_addr`=0; `run_en` cycles 7..20; `done`=1 from 21 and held.
- Sequence and wrap: four start/halt rounds -> `prog_num` 0,1,2,0; `load_addr` 0,256,512,0 at each `fetch_load`.
- Simultaneous and ignored events:
  - `start`+`halt` in the same RUN cycle -> DONE, `prog_num` unchanged.
  - `start` held high through RUN -> no relaunch until DONE.
- Reset mid-run: `reset` during RUN of program 1 -> next cycle IDLE, `prog_num`=0, `run_en`=0, `done`=0.
- Watchdog (`PROG_SEQ_WATCHDOG_EN`, `WDOG_CYCLES`=16): start, no halt -> `run_en` exactly 16 cycles, then `done`=1 and `timeout`=1; the next start clears `timeout`.
